// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers: shift-add multiply and
// restoring divide, one bit per cycle, plus single-cycle mthi/mtlo writes.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic                 is_div;
  logic                 neg_res;
  logic                 neg_rem;
  logic                 dz;
  logic [WIDTH-1:0]     mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     rem;

  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;
  logic [WIDTH-1:0]     addend;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH-1:0]     div_diff;
  logic                 div_ge;
  logic [WIDTH-1:0]     rem_next;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quot_fix;
  logic [WIDTH-1:0]     rem_fix;

  // Datapath: operand magnitudes, one iteration step, and final sign fix-up.
  always_comb begin
    abs_a     = (op[0] && a[WIDTH-1]) ? -a : a;
    abs_b     = (op[0] && b[WIDTH-1]) ? -b : b;
    addend    = acc[0] ? mcand : '0;
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    div_shift = {rem, acc[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, mcand});
    div_diff  = div_shift[WIDTH-1:0] - mcand;
    rem_next  = div_ge ? div_diff : div_shift[WIDTH-1:0];
    prod_fix  = neg_res ? -acc : acc;
    quot_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix   = neg_rem ? -rem : rem;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      dz       <= 1'b0;
      mcand    <= '0;
      acc      <= '0;
      rem      <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            case (op)
              3'b100: hi <= a;
              3'b101: lo <= a;
              3'b000, 3'b001: begin
                mcand   <= abs_a;
                acc     <= {{WIDTH{1'b0}}, abs_b};
                rem     <= '0;
                is_div  <= 1'b0;
                neg_res <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_rem <= 1'b0;
                dz      <= 1'b0;
                cnt     <= '0;
                busy    <= 1'b1;
                state   <= CALC;
              end
              3'b010, 3'b011: begin
                mcand   <= abs_b;
                acc     <= {{WIDTH{1'b0}}, abs_a};
                rem     <= '0;
                is_div  <= 1'b1;
                neg_res <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_rem <= op[0] & a[WIDTH-1];
                dz      <= (b == '0);
                cnt     <= '0;
                busy    <= 1'b1;
                state   <= CALC;
              end
              default: ;
            endcase
          end
        end
        CALC: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            // Divide keeps the quotient in the low half, shifting dividend bits out of its top.
            if (is_div) begin
              acc[WIDTH-1:0] <= {acc[WIDTH-2:0], div_ge};
              rem            <= rem_next;
            end else begin
              acc <= {mul_sum, acc[WIDTH-1:1]};
            end
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_CNT) state <= FIX;
          end
        end
        FIX: begin
          busy  <= 1'b0;
          state <= IDLE;
          if (!flush) begin
            done <= 1'b1;
            if (is_div) begin
              // With a zero divisor the remainder path already reproduces the original dividend.
              hi       <= rem_fix;
              lo       <= dz ? '1 : quot_fix;
              div_zero <= dz;
            end else begin
              {hi, lo} <= prod_fix;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench: directed 32-bit cases plus a randomised 8-bit run
// against an arithmetic reference model, including flush and mid-op reset.
module tb_mult_div_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_w, start_w, flush_w, busy_w, done_w, dz_w;
  logic [2:0]  op_w;
  logic [31:0] a_w, b_w, hi_w, lo_w;

  logic        rst_n, start_n, flush_n, busy_n, done_n, dz_n;
  logic [2:0]  op_n;
  logic [7:0]  a_n, b_n, hi_n, lo_n;

  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut_wide (
    .clk(clk), .rst(rst_w), .start(start_w), .op(op_w), .a(a_w), .b(b_w),
    .flush(flush_w), .busy(busy_w), .done(done_w), .div_zero(dz_w),
    .hi(hi_w), .lo(lo_w)
  );

  mult_div_unit #(.WIDTH(8), .CNT_W(4)) dut_narrow (
    .clk(clk), .rst(rst_n), .start(start_n), .op(op_n), .a(a_n), .b(b_n),
    .flush(flush_n), .busy(busy_n), .done(done_n), .div_zero(dz_n),
    .hi(hi_n), .lo(lo_n)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] ref_hi_w = '0, ref_lo_w = '0;
  longint unsigned ref_hi_n = 0, ref_lo_n = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Reference: full-width integer arithmetic on the operands as written.
  function automatic void model(input logic [2:0] op, input longint unsigned a, input longint unsigned b,
                                input int w, output longint unsigned rhi, output longint unsigned rlo,
                                output logic rdz);
    longint unsigned mask = (64'd1 << w) - 64'd1;
    longint unsigned half = 64'd1 << (w - 1);
    longint signed   sa   = $signed(a ^ half) - $signed(half);
    longint signed   sb   = $signed(b ^ half) - $signed(half);
    longint unsigned up;
    longint signed   p;
    rdz = 1'b0;
    rhi = 0;
    rlo = 0;
    case (op)
      3'b000: begin up = a * b; rhi = (up >> w) & mask; rlo = up & mask; end
      3'b001: begin p = sa * sb; up = $unsigned(p); rhi = (up >> w) & mask; rlo = up & mask; end
      3'b010, 3'b011: begin
        if (b == 0) begin
          rdz = 1'b1; rhi = a; rlo = mask;
        end else if (op == 3'b010) begin
          rlo = a / b; rhi = a % b;
        end else begin
          rlo = $unsigned(sa / sb) & mask; rhi = $unsigned(sa % sb) & mask;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start_w = 1'b1; op_w = op; a_w = a; b_w = b;
  endtask

  // Issues one wide mult/div at the current negedge and returns at the negedge showing done.
  task automatic run_wide(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic exp_dz);
    int cyc = 0;
    bit held = 1'b1;
    applyStimulus(op, a, b);
    @(negedge clk);
    start_w = 1'b0;
    while (busy_w && cyc < 100) begin
      cyc++;
      if (hi_w !== ref_hi_w || lo_w !== ref_lo_w || done_w !== 1'b0) held = 1'b0;
      @(negedge clk);
    end
    checkOutput({tag, " busy cycles"}, 64'(cyc), 64'd33);
    checkOutput({tag, " hold"}, 64'(held), 64'd1);
    checkOutput({tag, " done"}, 64'(done_w), 64'd1);
    checkOutput({tag, " hi"}, 64'(hi_w), 64'(exp_hi));
    checkOutput({tag, " lo"}, 64'(lo_w), 64'(exp_lo));
    checkOutput({tag, " div_zero"}, 64'(dz_w), 64'(exp_dz));
    ref_hi_w = exp_hi;
    ref_lo_w = exp_lo;
  endtask

  task automatic wide_tests();
    bit no_done = 1'b1;
    applyStimulus(3'b100, 32'h1234_5678, 32'h0);
    @(negedge clk);
    start_w = 1'b0;
    checkOutput("mthi hi", 64'(hi_w), 64'h1234_5678);
    checkOutput("mthi busy", 64'(busy_w), 64'd0);
    ref_hi_w = 32'h1234_5678;
    applyStimulus(3'b101, 32'hCAFE_0001, 32'h0);
    @(negedge clk);
    start_w = 1'b0;
    checkOutput("mtlo lo", 64'(lo_w), 64'hCAFE_0001);
    ref_lo_w = 32'hCAFE_0001;

    run_wide("multu max", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_wide("mult neg", 3'b001, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_wide("div neg", 3'b011, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_wide("divu zero", 3'b010, 32'h0000_0064, 32'h0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
    run_wide("div ovf", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    run_wide("div zero neg", 3'b011, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
    @(negedge clk);
    checkOutput("done pulse end", 64'(done_w), 64'd0);
    checkOutput("div_zero pulse end", 64'(dz_w), 64'd0);

    // Flush on cycle 10 with an mthi attempted while busy.
    applyStimulus(3'b001, 32'h0000_0005, 32'h0000_0007);
    @(negedge clk);
    start_w = 1'b0;
    repeat (4) @(negedge clk);
    applyStimulus(3'b100, 32'hDEAD_BEEF, 32'h0);
    @(negedge clk);
    start_w = 1'b0;
    repeat (4) @(negedge clk);
    flush_w = 1'b1;
    @(negedge clk);
    flush_w = 1'b0;
    checkOutput("flush busy", 64'(busy_w), 64'd0);
    checkOutput("flush done", 64'(done_w), 64'd0);
    checkOutput("flush hi", 64'(hi_w), 64'(ref_hi_w));
    checkOutput("flush lo", 64'(lo_w), 64'(ref_lo_w));
    repeat (40) begin
      if (done_w !== 1'b0 || busy_w !== 1'b0) no_done = 1'b0;
      @(negedge clk);
    end
    checkOutput("flush no done", 64'(no_done), 64'd1);

    applyStimulus(3'b100, 32'h5555_AAAA, 32'h0);
    flush_w = 1'b1;
    @(negedge clk);
    start_w = 1'b0; flush_w = 1'b0;
    checkOutput("idle flush drops start", 64'(hi_w), 64'(ref_hi_w));
  endtask

  // One randomised transaction on the 8-bit unit.
  task automatic narrow_step();
    int choice = $urandom_range(0, 9);
    logic [7:0] a = 8'($urandom);
    logic [7:0] b;
    logic [2:0] op;
    longint unsigned ehi, elo;
    logic edz;
    int mode, k, cyc;
    bit aborted;
    case ($urandom_range(0, 7))
      0: b = 8'h00;
      1: b = 8'hFF;
      default: b = 8'($urandom);
    endcase
    if ($urandom_range(0, 9) == 0) a = 8'h80;
    if (choice == 0) begin
      op = {2'b10, 1'($urandom)};
      start_n = 1'b1; op_n = op; a_n = a; b_n = b;
      @(negedge clk);
      start_n = 1'b0;
      if (op[0]) ref_lo_n = a; else ref_hi_n = a;
      checkOutput("rnd mthi/mtlo hi", 64'(hi_n), ref_hi_n);
      checkOutput("rnd mthi/mtlo lo", 64'(lo_n), ref_lo_n);
      checkOutput("rnd mthi/mtlo busy", 64'(busy_n), 64'd0);
    end else if (choice == 1 || choice == 2) begin
      op = (choice == 1) ? {2'b11, 1'($urandom)} : 3'($urandom);
      start_n = 1'b1; op_n = op; a_n = a; b_n = b; flush_n = (choice == 2);
      @(negedge clk);
      start_n = 1'b0; flush_n = 1'b0;
      checkOutput("rnd ignored busy", 64'(busy_n), 64'd0);
      checkOutput("rnd ignored hi", 64'(hi_n), ref_hi_n);
      checkOutput("rnd ignored lo", 64'(lo_n), ref_lo_n);
    end else begin
      op = 3'($urandom_range(0, 3));
      model(op, 64'(a), 64'(b), 8, ehi, elo, edz);
      mode = $urandom_range(0, 5);
      k = $urandom_range(1, 9);
      start_n = 1'b1; op_n = op; a_n = a; b_n = b;
      @(negedge clk);
      start_n = 1'b0;
      cyc = 0;
      aborted = 1'b0;
      while (busy_n && cyc < 50 && !aborted) begin
        cyc++;
        if (mode < 2 && cyc == k) begin
          if (mode == 0) flush_n = 1'b1; else rst_n = 1'b1;
          @(negedge clk);
          flush_n = 1'b0;
          if (mode == 1) begin
            rst_n = 1'b0; ref_hi_n = 0; ref_lo_n = 0;
          end
          checkOutput("rnd abort busy", 64'(busy_n), 64'd0);
          checkOutput("rnd abort done", 64'(done_n), 64'd0);
          checkOutput("rnd abort hi", 64'(hi_n), ref_hi_n);
          checkOutput("rnd abort lo", 64'(lo_n), ref_lo_n);
          aborted = 1'b1;
        end else begin
          start_n = ($urandom_range(0, 3) == 0);
          op_n = 3'($urandom); a_n = 8'($urandom); b_n = 8'($urandom);
          @(negedge clk);
        end
      end
      start_n = 1'b0;
      if (!aborted) begin
        checkOutput("rnd busy cycles", 64'(cyc), 64'd9);
        checkOutput("rnd done", 64'(done_n), 64'd1);
        checkOutput("rnd hi", 64'(hi_n), ehi);
        checkOutput("rnd lo", 64'(lo_n), elo);
        checkOutput("rnd div_zero", 64'(dz_n), 64'(edz));
        ref_hi_n = ehi;
        ref_lo_n = elo;
      end
    end
  endtask

  initial begin
    rst_w = 1'b1; start_w = 1'b0; flush_w = 1'b0; op_w = '0; a_w = '0; b_w = '0;
    rst_n = 1'b1; start_n = 1'b0; flush_n = 1'b0; op_n = '0; a_n = '0; b_n = '0;
    repeat (2) @(negedge clk);
    rst_w = 1'b0; rst_n = 1'b0;
    checkOutput("reset hi", 64'(hi_w), 64'd0);
    checkOutput("reset lo", 64'(lo_w), 64'd0);
    checkOutput("reset busy", 64'(busy_w), 64'd0);
    checkOutput("reset done", 64'(done_w), 64'd0);
    checkOutput("reset div_zero", 64'(dz_w), 64'd0);
    checkOutput("reset narrow hi", 64'(hi_n), 64'd0);
    wide_tests();
    repeat (300) narrow_step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
